cp0_core_param: RTL and testbench
=================================

Name: cp0_core_param

Overview:
- Parametrised next-generation CP0 for the MIPS32 pipeline; sits at the EX/MEM commit point.
- Holds the privileged registers: Index, Random, EntryLo0/1, PageMask, Wired, BadVAddr, Count, EntryHi, Compare, Status, Cause, EPC, PRId, EBase, Config.
- Prioritises the exception flags, commits at most one exception per unstalled cycle and supplies the redirect PC.
- New relative to the previous generation:
  - configurable TLB depth, hardware interrupt count and Count divider;
  - a working timer interrupt (Cause.TI);
  - Cause.IV interrupt vectoring;
  - a registered interrupt sampler.

Parameters:
- TLB_ENTRIES, 16, number of TLB lines (power of two, 2..64); sets Index/Random/Wired width IW = log2(TLB_ENTRIES).
- HW_INT_NUM, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT_NUM-1:2].
- COUNT_DIV, 2, Count increments once every COUNT_DIV clocks (1..8).
- PRID_VAL, 32'h00018003, read-only PRId value.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; synchronous, active-low.
- stall_i, in, 1, commit stage stalled; blocks mtc0 writes and exception commit.
- we_i, in, 1, mtc0 write enable.
- waddr_i, in, 5, mtc0 register number.
- wsel_i, in, 3, mtc0 select.
- wdata_i, in, 32, mtc0 data.
- raddr_i, in, 5, mfc0 register number.
- rsel_i, in, 3, mfc0 select.
- rdata_o, out, 32, mfc0 data (combinational).
- int_i, in, HW_INT_NUM, hardware interrupt lines (level-sensitive).
- pc_i, in, 32, PC of the committing instruction.
- in_ds_i, in, 1, committing instruction is in a delay slot.
- exc_flags_i, in, EXC_W, one-hot-or-more exception flags, packed in package order.
- eret_i, in, 1, ERET committing.
- mem_addr_i, in, 32, data virtual address.
- tlbp_i, in, 1, TLBP result write.
- tlbp_miss_i, in, 1, TLBP missed.
- tlbp_idx_i, in, IW, TLBP hit index.
- tlbr_i, in, 1, TLBR result write.
- tlbr_hi_i, in, 32, TLBR EntryHi data.
- tlbr_lo0_i, in, 32, TLBR EntryLo0 data.
- tlbr_lo1_i, in, 32, TLBR EntryLo1 data.
- tlbr_mask_i, in, 32, TLBR PageMask data.
- flush_o, out, 1, exception or ERET taken this cycle.
- redirect_pc_o, out, 32, fetch target when flush_o=1.
- int_pending_o, out, 1, enabled interrupt pending.
- status_o, out, 32, Status register.
- cause_o, out, 32, Cause register.
- epc_o, out, 32, EPC register.
- entryhi_o, out, 32, EntryHi register.
- entrylo0_o, out, 32, EntryLo0 register.
- entrylo1_o, out, 32, EntryLo1 register.
- pagemask_o, out, 32, PageMask register.
- index_o, out, 32, Index register.
- random_o, out, 32, Random register.

Behaviour:
- Reset (rst=0 at an edge):
  - Status = 0x0040_0000 (BEV=1); Cause, EPC, Count, Compare, BadVAddr = 0;
  - Index, EntryLo0/1, EntryHi, PageMask, Wired = 0;
  - Random = TLB_ENTRIES-1; EBase = 0x8000_0000; Config = 0x0000_8000;
  - flush_o = 0; divider counter = 0.
  - Reset mid-operation discards any pending commit.
- Count:
  - Divider counts 0..COUNT_DIV-1; Count increments on wrap, wrapping at 2^32.
  - The divider and Count run during stall.
  - mtc0 Count loads the value and clears the divider.
- Timer interrupt:
  - Cause.TI (bit 30) is set on the edge after Count==Compare while Compare!=0, and stays set.
  - mtc0 Compare clears TI; if a set event coincides with the clear, the clear wins.
- Interrupt sampling:
  - Cause.IP[7:2] latches int_i every cycle, independent of stall; unused IP bits read 0.
  - IP7 is ORed with TI.
- Pending and exception selection:
  - int_pending_o = Status.IE & ~Status.EXL & |(Status.IM & Cause.IP).
  - Exception select (combinational, highest first): Int, AdEL-fetch, TLBL-fetch, RI, Sys, Bp, Ov, Tr, AdEL-data, TLBL-data, TLBS, Mod, AdES.
  - All exception selection is suppressed while stall_i=1.
- Exception commit (next edge):
  - EPC = pc_i - 4 if in_ds_i, else pc_i; Cause.BD = in_ds_i.
  - Cause.ExcCode is set; Status.EXL = 1.
  - EPC and BD are updated only if EXL was 0 beforehand.
  - BadVAddr is written for address and TLB exceptions: pc_i for fetch causes, mem_addr_i otherwise.
  - EntryHi.VPN2 is written for TLBL, TLBS and Mod.
- Redirect target:
  - Base = BEV ? 0xBFC0_0200 : EBase.
  - Offset: 0x000 for TLB refill; 0x200 for Int when Cause.IV=1; otherwise 0x180.
  - ERET (with no exception selected) targets EPC, clears EXL and asserts flush_o.
- mtc0:
  - Ignored when stall_i=1.
  - Writable fields: Status (full), Cause[9:8,23,22], EPC, Compare, Count, EBase[29:12] (sel 1), Index[IW-1:0], EntryHi, EntryLo0/1, PageMask.
  - Writing Wired masks the value to IW bits and resets Random to TLB_ENTRIES-1.
  - When an exception commits in the same cycle as an mtc0, the exception's fields win.
- Random:
  - Decrements each cycle.
  - When Random==Wired, the next value is TLB_ENTRIES-1.
  - If Wired=TLB_ENTRIES-1, Random holds.
- TLB result writes:
  - TLBP writes Index.P = tlbp_miss_i and Index[IW-1:0] = tlbp_idx_i.
  - TLBR writes EntryHi, EntryLo0/1 and PageMask.
  - TLBP/TLBR take priority over mtc0 to the same register.
- mfc0: unimplemented register numbers read 0; PRId with sel 1 returns EBase.

Decomposition:
- Package cp0_pkg holds:
  - the CP0 register numbers;
  - the ExcCode enum;
  - the exc_flags_i bit-index enum and EXC_W;
  - Status/Cause field-position localparams;
  - vector base and offset constants.
- Sub-module cp0_exc_prio: the combinational priority encoder (flags, int_pending, eret → sel_valid, exccode, is_refill, is_fetch).

Test Plan:
- Reset, then read Status, Random, EBase → 0x0040_0000, TLB_ENTRIES-1 (15), 0x8000_0000.
- COUNT_DIV=2; mtc0 Compare=5; wait → TI=1 when Count reaches 5; mtc0 Status=0x0000_8001 → int_pending_o=1; mtc0 Compare=9 → TI=0.
- Sys with in_ds_i=1, pc_i=0x8000_0104 → EPC=0x8000_0100, BD=1, ExcCode=8, redirect_pc_o=0xBFC0_0380.
- After mtc0 Status=0, TLBL-data refill at mem_addr_i=0x1234_5678 → BadVAddr=0x1234_5678, EntryHi[31:13]=0x091A2, redirect_pc_o=0x8000_0000.
- Sys and Ov both asserted with stall_i=1 → no flush and no state change; stall released → ExcCode=8 (Sys wins).
- mtc0 Wired=3; observe Random cycle 15→3→15; exception with EXL=1 → EPC unchanged, ERET → redirect_pc_o=EPC, EXL=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 block: register numbers, exception codes,
// exception-flag bit positions, Status/Cause field positions and vector constants.
package cp0_pkg;

  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_RANDOM   = 5'd1;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_PAGEMASK = 5'd5;
  localparam logic [4:0] CP0_WIRED    = 5'd6;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;
  localparam logic [4:0] CP0_CONFIG   = 5'd16;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exccode_e;

  // Bit positions inside exc_flags_i; _I = instruction fetch, _D = data access.
  typedef enum int unsigned {
    F_ADEL_I = 0,
    F_TLBL_I = 1,
    F_RI     = 2,
    F_SYS    = 3,
    F_BP     = 4,
    F_OV     = 5,
    F_TR     = 6,
    F_ADEL_D = 7,
    F_TLBL_D = 8,
    F_TLBS   = 9,
    F_MOD    = 10,
    F_ADES   = 11
  } exc_flag_e;

  localparam int EXC_W = 12;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_BEV    = 22;

  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_WP     = 22;
  localparam int CA_IV     = 23;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] CONFIG_VAL   = 32'h0000_8000;
  localparam logic [31:0] VEC_BEV_BASE = 32'hBFC0_0200;
  localparam logic [31:0] OFF_REFILL   = 32'h0000_0000;
  localparam logic [31:0] OFF_GENERAL  = 32'h0000_0180;
  localparam logic [31:0] OFF_INT_IV   = 32'h0000_0200;

endpackage

// File: rtl/cp0_exc_prio.sv
// Combinational exception priority encoder: picks the highest-priority cause
// and reports whether it is a TLB refill candidate or a fetch-side fault.
module cp0_exc_prio
  import cp0_pkg::*;
(
  input  logic [EXC_W-1:0] flags,
  input  logic             int_pending,
  input  logic             eret,
  output logic             sel_valid,
  output exccode_e         exccode,
  output logic             is_refill,
  output logic             is_fetch,
  output logic             eret_valid
);

  // NOTE: every output gets a default before the if-chain so no latch is inferred.
  always_comb begin
    sel_valid = 1'b1;
    exccode   = EXC_INT;
    is_refill = 1'b0;
    is_fetch  = 1'b0;
    if (int_pending) begin
      exccode = EXC_INT;
    end else if (flags[F_ADEL_I]) begin
      exccode  = EXC_ADEL;
      is_fetch = 1'b1;
    end else if (flags[F_TLBL_I]) begin
      exccode   = EXC_TLBL;
      is_fetch  = 1'b1;
      is_refill = 1'b1;
    end else if (flags[F_RI]) begin
      exccode = EXC_RI;
    end else if (flags[F_SYS]) begin
      exccode = EXC_SYS;
    end else if (flags[F_BP]) begin
      exccode = EXC_BP;
    end else if (flags[F_OV]) begin
      exccode = EXC_OV;
    end else if (flags[F_TR]) begin
      exccode = EXC_TR;
    end else if (flags[F_ADEL_D]) begin
      exccode = EXC_ADEL;
    end else if (flags[F_TLBL_D]) begin
      exccode   = EXC_TLBL;
      is_refill = 1'b1;
    end else if (flags[F_TLBS]) begin
      exccode   = EXC_TLBS;
      is_refill = 1'b1;
    end else if (flags[F_MOD]) begin
      exccode = EXC_MOD;
    end else if (flags[F_ADES]) begin
      exccode = EXC_ADES;
    end else begin
      sel_valid = 1'b0;
    end
    eret_valid = eret & ~sel_valid;
  end

endmodule

// File: rtl/cp0_core_param.sv
// Parametrised CP0 at the EX/MEM commit point: privileged registers, timer,
// interrupt sampling, exception commit and redirect PC generation.
module cp0_core_param
  import cp0_pkg::*;
#(
  parameter int          TLB_ENTRIES = 16,
  parameter int          HW_INT_NUM  = 6,
  parameter int          COUNT_DIV   = 2,
  parameter logic [31:0] PRID_VAL    = 32'h0001_8003,
  localparam int         IW          = $clog2(TLB_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [2:0]            wsel_i,
  input  logic [31:0]           wdata_i,
  input  logic [4:0]            raddr_i,
  input  logic [2:0]            rsel_i,
  output logic [31:0]           rdata_o,
  input  logic [HW_INT_NUM-1:0] int_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_ds_i,
  input  logic [EXC_W-1:0]      exc_flags_i,
  input  logic                  eret_i,
  input  logic [31:0]           mem_addr_i,
  input  logic                  tlbp_i,
  input  logic                  tlbp_miss_i,
  input  logic [IW-1:0]         tlbp_idx_i,
  input  logic                  tlbr_i,
  input  logic [31:0]           tlbr_hi_i,
  input  logic [31:0]           tlbr_lo0_i,
  input  logic [31:0]           tlbr_lo1_i,
  input  logic [31:0]           tlbr_mask_i,
  output logic                  flush_o,
  output logic [31:0]           redirect_pc_o,
  output logic                  int_pending_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic [31:0]           entryhi_o,
  output logic [31:0]           entrylo0_o,
  output logic [31:0]           entrylo1_o,
  output logic [31:0]           pagemask_o,
  output logic [31:0]           index_o,
  output logic [31:0]           random_o
);

  localparam logic [IW-1:0] RAND_MAX = IW'(TLB_ENTRIES - 1);
  localparam logic [2:0]    DIV_LAST = 3'(COUNT_DIV - 1);

  logic [31:0] status_q, epc_q, count_q, compare_q, badvaddr_q;
  logic [31:0] entryhi_q, entrylo0_q, entrylo1_q, pagemask_q;
  logic [17:0] ebase_q;
  logic [2:0]  div_q;
  logic        cause_bd_q, cause_ti_q, cause_iv_q, cause_wp_q;
  logic [1:0]  cause_sw_q;
  exccode_e    cause_exc_q;
  logic [HW_INT_NUM-1:0] hw_ip_q;
  logic        index_p_q;
  logic [IW-1:0] index_q, random_q, wired_q;

  logic [5:0]  hw_ext;
  logic [7:0]  ip_full;
  logic [31:0] ebase_full, vec_base, vec_off, bad_src;
  logic        wr_sel0, wr_sel1;
  logic        sel_valid, is_refill, is_fetch, eret_valid;
  logic        exc_take, eret_take, upd_badvaddr, upd_vpn;
  exccode_e    exccode;

  assign wr_sel0 = we_i & ~stall_i & (wsel_i == 3'd0);
  assign wr_sel1 = we_i & ~stall_i & (wsel_i == 3'd1);

  always_comb begin
    hw_ext                 = '0;
    hw_ext[HW_INT_NUM-1:0] = hw_ip_q;
  end

  assign ip_full       = {hw_ext[5] | cause_ti_q, hw_ext[4:0], cause_sw_q};
  assign int_pending_o = status_q[ST_IE] & ~status_q[ST_EXL] &
                         (|(status_q[ST_IM_LO +: 8] & ip_full));
  assign ebase_full    = {2'b10, ebase_q, 12'h000};

  // Stall masks every request before it reaches the encoder.
  cp0_exc_prio u_prio (
    .flags       (stall_i ? '0 : exc_flags_i),
    .int_pending (int_pending_o & ~stall_i),
    .eret        (eret_i & ~stall_i),
    .sel_valid   (sel_valid),
    .exccode     (exccode),
    .is_refill   (is_refill),
    .is_fetch    (is_fetch),
    .eret_valid  (eret_valid)
  );

  assign exc_take     = sel_valid;
  assign eret_take    = eret_valid;
  assign upd_vpn      = (exccode == EXC_TLBL) || (exccode == EXC_TLBS) || (exccode == EXC_MOD);
  assign upd_badvaddr = upd_vpn || (exccode == EXC_ADEL) || (exccode == EXC_ADES);
  assign bad_src      = is_fetch ? pc_i : mem_addr_i;

  // Refill vector only applies on a first-level miss (EXL clear).
  always_comb begin
    vec_base = status_q[ST_BEV] ? VEC_BEV_BASE : ebase_full;
    if (is_refill && !status_q[ST_EXL])           vec_off = OFF_REFILL;
    else if (exccode == EXC_INT && cause_iv_q)    vec_off = OFF_INT_IV;
    else                                          vec_off = OFF_GENERAL;
  end

  assign flush_o       = rst & (exc_take | eret_take);
  assign redirect_pc_o = eret_take ? epc_q : vec_base + vec_off;

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      cause_ti_q <= 1'b0;
    end else begin
      if (wr_sel0 && waddr_i == CP0_COUNT) begin
        count_q <= wdata_i;
        div_q   <= '0;
      end else if (div_q == DIV_LAST) begin
        div_q   <= '0;
        count_q <= count_q + 32'd1;
      end else begin
        div_q   <= div_q + 3'd1;
      end
      if (wr_sel0 && waddr_i == CP0_COMPARE) begin
        compare_q  <= wdata_i;
        cause_ti_q <= 1'b0;
      end else if (count_q == compare_q && compare_q != '0) begin
        cause_ti_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wired_q  <= '0;
      random_q <= RAND_MAX;
    end else if (wr_sel0 && waddr_i == CP0_WIRED) begin
      wired_q  <= wdata_i[IW-1:0];
      random_q <= RAND_MAX;
    end else if (random_q == wired_q) begin
      random_q <= RAND_MAX;
    end else begin
      random_q <= random_q - IW'(1);
    end
  end

  // Priority within each register: mtc0 < TLB result < exception.
  always_ff @(posedge clk) begin
    if (!rst) begin
      index_p_q  <= 1'b0;
      index_q    <= '0;
      entryhi_q  <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
      pagemask_q <= '0;
    end else begin
      if (wr_sel0 && waddr_i == CP0_INDEX)    index_q    <= wdata_i[IW-1:0];
      if (wr_sel0 && waddr_i == CP0_ENTRYHI)  entryhi_q  <= wdata_i;
      if (wr_sel0 && waddr_i == CP0_ENTRYLO0) entrylo0_q <= wdata_i;
      if (wr_sel0 && waddr_i == CP0_ENTRYLO1) entrylo1_q <= wdata_i;
      if (wr_sel0 && waddr_i == CP0_PAGEMASK) pagemask_q <= wdata_i;
      if (tlbp_i) begin
        index_p_q <= tlbp_miss_i;
        index_q   <= tlbp_idx_i;
      end
      if (tlbr_i) begin
        entryhi_q  <= tlbr_hi_i;
        entrylo0_q <= tlbr_lo0_i;
        entrylo1_q <= tlbr_lo1_i;
        pagemask_q <= tlbr_mask_i;
      end
      if (exc_take && upd_vpn) entryhi_q[31:13] <= bad_src[31:13];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      status_q    <= STATUS_RESET;
      cause_bd_q  <= 1'b0;
      cause_iv_q  <= 1'b0;
      cause_wp_q  <= 1'b0;
      cause_sw_q  <= '0;
      cause_exc_q <= EXC_INT;
      hw_ip_q     <= '0;
      epc_q       <= '0;
      badvaddr_q  <= '0;
      ebase_q     <= '0;
    end else begin
      hw_ip_q <= int_i;
      if (wr_sel0 && waddr_i == CP0_STATUS) status_q <= wdata_i;
      if (wr_sel0 && waddr_i == CP0_CAUSE) begin
        cause_sw_q <= wdata_i[CA_IP_LO +: 2];
        cause_iv_q <= wdata_i[CA_IV];
        cause_wp_q <= wdata_i[CA_WP];
      end
      if (wr_sel0 && waddr_i == CP0_EPC)  epc_q   <= wdata_i;
      if (wr_sel1 && waddr_i == CP0_PRID) ebase_q <= wdata_i[29:12];
      if (eret_take) status_q[ST_EXL] <= 1'b0;
      if (exc_take) begin
        status_q[ST_EXL] <= 1'b1;
        cause_exc_q      <= exccode;
        if (!status_q[ST_EXL]) begin
          epc_q      <= in_ds_i ? pc_i - 32'd4 : pc_i;
          cause_bd_q <= in_ds_i;
        end
        if (upd_badvaddr) badvaddr_q <= bad_src;
      end
    end
  end

  assign status_o   = status_q;
  assign cause_o    = {cause_bd_q, cause_ti_q, 6'b0, cause_iv_q, cause_wp_q, 6'b0,
                       ip_full, 1'b0, cause_exc_q, 2'b00};
  assign epc_o      = epc_q;
  assign entryhi_o  = entryhi_q;
  assign entrylo0_o = entrylo0_q;
  assign entrylo1_o = entrylo1_q;
  assign pagemask_o = pagemask_q;
  assign index_o    = {index_p_q, {(31 - IW){1'b0}}, index_q};
  assign random_o   = 32'(random_q);

  always_comb begin
    rdata_o = '0;
    if (rsel_i == 3'd0) begin
      case (raddr_i)
        CP0_INDEX:    rdata_o = index_o;
        CP0_RANDOM:   rdata_o = random_o;
        CP0_ENTRYLO0: rdata_o = entrylo0_q;
        CP0_ENTRYLO1: rdata_o = entrylo1_q;
        CP0_PAGEMASK: rdata_o = pagemask_q;
        CP0_WIRED:    rdata_o = 32'(wired_q);
        CP0_BADVADDR: rdata_o = badvaddr_q;
        CP0_COUNT:    rdata_o = count_q;
        CP0_ENTRYHI:  rdata_o = entryhi_q;
        CP0_COMPARE:  rdata_o = compare_q;
        CP0_STATUS:   rdata_o = status_q;
        CP0_CAUSE:    rdata_o = cause_o;
        CP0_EPC:      rdata_o = epc_q;
        CP0_PRID:     rdata_o = PRID_VAL;
        CP0_CONFIG:   rdata_o = CONFIG_VAL;
        default:      rdata_o = '0;
      endcase
    end else if (rsel_i == 3'd1 && raddr_i == CP0_PRID) begin
      rdata_o = ebase_full;
    end
  end

endmodule

// File: tb/tb_cp0_core_param.sv
// Directed bench for cp0_core_param: expected values are queued when stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_cp0_core_param;
  import cp0_pkg::*;

  localparam int TLB_ENTRIES = 16;
  localparam int HW_INT_NUM  = 6;
  localparam int COUNT_DIV   = 2;
  localparam int IW          = $clog2(TLB_ENTRIES);

  logic clk = 1'b0;
  logic rst, stall_i, we_i, in_ds_i, eret_i;
  logic tlbp_i, tlbp_miss_i, tlbr_i;
  logic [4:0] waddr_i, raddr_i;
  logic [2:0] wsel_i, rsel_i;
  logic [31:0] wdata_i, rdata_o, pc_i, mem_addr_i;
  logic [31:0] tlbr_hi_i, tlbr_lo0_i, tlbr_lo1_i, tlbr_mask_i;
  logic [HW_INT_NUM-1:0] int_i;
  logic [EXC_W-1:0] exc_flags_i;
  logic [IW-1:0] tlbp_idx_i;
  logic flush_o, int_pending_o;
  logic [31:0] redirect_pc_o, status_o, cause_o, epc_o, entryhi_o;
  logic [31:0] entrylo0_o, entrylo1_o, pagemask_o, index_o, random_o;

  always #5 clk = ~clk;

  cp0_core_param #(
    .TLB_ENTRIES (TLB_ENTRIES),
    .HW_INT_NUM  (HW_INT_NUM),
    .COUNT_DIV   (COUNT_DIV),
    .PRID_VAL    (32'h0001_8003)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .we_i          (we_i),
    .waddr_i       (waddr_i),
    .wsel_i        (wsel_i),
    .wdata_i       (wdata_i),
    .raddr_i       (raddr_i),
    .rsel_i        (rsel_i),
    .rdata_o       (rdata_o),
    .int_i         (int_i),
    .pc_i          (pc_i),
    .in_ds_i       (in_ds_i),
    .exc_flags_i   (exc_flags_i),
    .eret_i        (eret_i),
    .mem_addr_i    (mem_addr_i),
    .tlbp_i        (tlbp_i),
    .tlbp_miss_i   (tlbp_miss_i),
    .tlbp_idx_i    (tlbp_idx_i),
    .tlbr_i        (tlbr_i),
    .tlbr_hi_i     (tlbr_hi_i),
    .tlbr_lo0_i    (tlbr_lo0_i),
    .tlbr_lo1_i    (tlbr_lo1_i),
    .tlbr_mask_i   (tlbr_mask_i),
    .flush_o       (flush_o),
    .redirect_pc_o (redirect_pc_o),
    .int_pending_o (int_pending_o),
    .status_o      (status_o),
    .cause_o       (cause_o),
    .epc_o         (epc_o),
    .entryhi_o     (entryhi_o),
    .entrylo0_o    (entrylo0_o),
    .entrylo1_o    (entrylo1_o),
    .pagemask_o    (pagemask_o),
    .index_o       (index_o),
    .random_o      (random_o)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Reference model for the vector and EPC arithmetic.
  function automatic logic [31:0] model_vec(input logic bev, input logic [31:0] ebase,
                                            input logic refill, input logic exl);
    logic [31:0] base;
    base = bev ? 32'hBFC0_0200 : ebase;
    return (refill && !exl) ? base : base + 32'h180;
  endfunction

  function automatic logic [31:0] model_epc(input logic [31:0] pc, input logic ds);
    return ds ? pc - 32'd4 : pc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    we_i    = 1'b1;
    waddr_i = a;
    wsel_i  = s;
    wdata_i = d;
    step();
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [2:0] s, output logic [31:0] d);
    raddr_i = a;
    rsel_i  = s;
    #1;
    d = rdata_o;
  endtask

  initial begin
    logic [31:0] d;
    logic        found;

    rst = 1'b0; stall_i = 1'b0; we_i = 1'b0; waddr_i = '0; wsel_i = '0; wdata_i = '0;
    raddr_i = '0; rsel_i = '0; int_i = '0; pc_i = '0; in_ds_i = 1'b0; eret_i = 1'b0;
    mem_addr_i = '0; tlbp_i = 1'b0; tlbp_miss_i = 1'b0; tlbp_idx_i = '0; tlbr_i = 1'b0;
    tlbr_hi_i = '0; tlbr_lo0_i = '0; tlbr_lo1_i = '0; tlbr_mask_i = '0;
    exc_flags_i = '0;
    exc_flags_i[F_SYS] = 1'b1;
    repeat (3) step();

    expect_val("reset_flush", 32'd0);          check({31'b0, flush_o});
    expect_val("reset_status", 32'h0040_0000); rd(CP0_STATUS, 3'd0, d); check(d);
    expect_val("reset_random", 32'd15);        rd(CP0_RANDOM, 3'd0, d); check(d);
    expect_val("reset_ebase", 32'h8000_0000);  rd(CP0_PRID, 3'd1, d);   check(d);
    expect_val("reset_count", 32'd0);          rd(CP0_COUNT, 3'd0, d);  check(d);
    exc_flags_i = '0;
    rst = 1'b1;

    // Timer interrupt
    mtc0(CP0_COMPARE, 3'd0, 32'd5);
    expect_val("ti_set", 32'd1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (cause_o[CA_TI]) found = 1'b1;
    end
    check({31'b0, found});
    expect_val("count_at_ti", 32'd5); rd(CP0_COUNT, 3'd0, d); check(d);

    pc_i = 32'h8000_0040;
    mtc0(CP0_STATUS, 3'd0, 32'h0000_8001);
    expect_val("int_pending", 32'd1); check({31'b0, int_pending_o});
    expect_val("int_flush", 32'd1);   check({31'b0, flush_o});
    expect_val("int_redirect", model_vec(1'b0, 32'h8000_0000, 1'b0, 1'b0)); check(redirect_pc_o);
    step();
    expect_val("int_exccode", 32'(EXC_INT)); check({27'b0, cause_o[6:2]});
    expect_val("int_epc", model_epc(32'h8000_0040, 1'b0)); check(epc_o);
    expect_val("int_pending_after", 32'd0); check({31'b0, int_pending_o});
    mtc0(CP0_COMPARE, 3'd0, 32'd9);
    expect_val("ti_cleared", 32'd0); check({31'b0, cause_o[CA_TI]});

    // Hardware interrupt sampling
    mtc0(CP0_STATUS, 3'd0, 32'h0040_0000);
    int_i = 6'b000001;
    step();
    expect_val("ip2_sampled", 32'd1); check({31'b0, cause_o[10]});
    int_i = '0;
    step();

    // Syscall in a delay slot with BEV=1
    exc_flags_i[F_SYS] = 1'b1; in_ds_i = 1'b1; pc_i = 32'h8000_0104;
    #1;
    expect_val("sys_flush", 32'd1); check({31'b0, flush_o});
    expect_val("sys_redirect", 32'hBFC0_0380); check(redirect_pc_o);
    step();
    exc_flags_i = '0; in_ds_i = 1'b0;
    expect_val("sys_epc", model_epc(32'h8000_0104, 1'b1)); check(epc_o);
    expect_val("sys_bd", 32'd1); check({31'b0, cause_o[CA_BD]});
    expect_val("sys_exccode", 32'd8); check({27'b0, cause_o[6:2]});

    // TLBL data refill with BEV=0
    mtc0(CP0_STATUS, 3'd0, 32'h0);
    exc_flags_i[F_TLBL_D] = 1'b1; mem_addr_i = 32'h1234_5678; pc_i = 32'h8000_0200;
    #1;
    expect_val("tlbl_redirect", model_vec(1'b0, 32'h8000_0000, 1'b1, 1'b0)); check(redirect_pc_o);
    step();
    exc_flags_i = '0;
    expect_val("tlbl_badvaddr", 32'h1234_5678); rd(CP0_BADVADDR, 3'd0, d); check(d);
    expect_val("tlbl_entryhi", 32'h1234_4000); check(entryhi_o);
    expect_val("tlbl_exccode", 32'd2); check({27'b0, cause_o[6:2]});
    expect_val("tlbl_epc", 32'h8000_0200); check(epc_o);

    // Stalled Sys+Ov plus a stalled mtc0: nothing may change
    stall_i = 1'b1;
    exc_flags_i[F_SYS] = 1'b1; exc_flags_i[F_OV] = 1'b1;
    #1;
    expect_val("stall_flush", 32'd0); check({31'b0, flush_o});
    we_i = 1'b1; waddr_i = CP0_EPC; wsel_i = 3'd0; wdata_i = 32'hDEAD_0000;
    step(); step();
    we_i = 1'b0;
    expect_val("stall_epc", 32'h8000_0200); check(epc_o);
    expect_val("stall_exccode", 32'd2); check({27'b0, cause_o[6:2]});
    expect_val("stall_status", 32'h0000_0002); check(status_o);
    stall_i = 1'b0;
    #1;
    expect_val("unstall_flush", 32'd1); check({31'b0, flush_o});
    expect_val("unstall_redirect", model_vec(1'b0, 32'h8000_0000, 1'b0, 1'b1)); check(redirect_pc_o);
    step();
    exc_flags_i = '0;
    expect_val("unstall_exccode", 32'd8); check({27'b0, cause_o[6:2]});
    expect_val("unstall_epc_kept", 32'h8000_0200); check(epc_o);

    // Wired / Random
    mtc0(CP0_WIRED, 3'd0, 32'd3);
    expect_val("random_after_wired", 32'd15); check(random_o);
    expect_val("wired_read", 32'd3); rd(CP0_WIRED, 3'd0, d); check(d);
    repeat (12) step();
    expect_val("random_at_wired", 32'd3); check(random_o);
    step();
    expect_val("random_wrap", 32'd15); check(random_o);

    // TLBP miss and PRId
    tlbp_i = 1'b1; tlbp_miss_i = 1'b1; tlbp_idx_i = 4'd5;
    step();
    tlbp_i = 1'b0; tlbp_miss_i = 1'b0;
    expect_val("tlbp_index", 32'h8000_0005); check(index_o);
    expect_val("prid", 32'h0001_8003); rd(CP0_PRID, 3'd0, d); check(d);

    // Nested exception keeps EPC, then ERET
    exc_flags_i[F_BP] = 1'b1; pc_i = 32'h8000_0500;
    step();
    exc_flags_i = '0;
    expect_val("nested_epc", 32'h8000_0200); check(epc_o);
    expect_val("nested_exccode", 32'd9); check({27'b0, cause_o[6:2]});
    eret_i = 1'b1;
    #1;
    expect_val("eret_flush", 32'd1); check({31'b0, flush_o});
    expect_val("eret_redirect", 32'h8000_0200); check(redirect_pc_o);
    step();
    eret_i = 1'b0;
    expect_val("eret_status", 32'h0000_0000); check(status_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
